// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg -- shared definitions for the rf_seq micro-sequencer.
//   Opcode constants, FSM state encodings and instruction field positions.
//   Instruction layout: [15:13] opcode, [12:10] rd, [9:7] ra, [6:4] rb,
//   [9:0] imm (LDI only).
//   No ports (package).
package rf_seq_pkg;

    localparam int unsigned DW = 16;

    // Opcodes
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_AND    = 3'b010;
    localparam logic [2:0] OP_OR     = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_MOV    = 3'b101;
    localparam logic [2:0] OP_LDI    = 3'b110;
    localparam logic [2:0] OP_CLRALL = 3'b111;

    // FSM state encodings
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_EXEC = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_CLR  = 3'd4;

    // Instruction field positions (3-bit fields are addressed by their LSB)
    localparam int unsigned OP_LSB = 13;
    localparam int unsigned RD_LSB = 10;
    localparam int unsigned RA_LSB = 7;
    localparam int unsigned RB_LSB = 4;
    localparam int unsigned IMM_W  = 10;

endpackage

// File: rtl/rf_seq_alu.sv
// rf_seq_alu -- combinational ALU for the rf_seq micro-sequencer.
//   op    in  3   opcode
//   a     in  16  operand A (register ra)
//   b     in  16  operand B (register rb)
//   imm   in  10  immediate for LDI
//   y     out 16  result, modulo 2^16
//   carry out 1   ADD carry-out / SUB borrow (a < b unsigned), 0 otherwise
module rf_seq_alu
    import rf_seq_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [IMM_W-1:0] imm,
    output logic [DW-1:0]    y,
    output logic             carry
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        // MSB of the widened difference is the borrow (set exactly when a < b)
        diff  = {1'b0, a} - {1'b0, b};
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                y     = sum[DW-1:0];
                carry = sum[DW];
            end
            OP_SUB: begin
                y     = diff[DW-1:0];
                carry = diff[DW];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_MOV:  y = a;
            OP_LDI:  y = {{(DW-IMM_W){1'b0}}, imm};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rf_seq.sv
// rf_seq -- single-issue micro-sequencer owning all ports of an 8x16
// two-read/one-write register file.
//   clk, reset          system clock; synchronous active-high reset
//   instr, instr_valid  instruction word and its valid strobe
//   instr_ready         high only in IDLE
//   done                one-cycle pulse on the instruction's final write
//   result              last value written, held until the next write
//   rf_rd_addr_a/b      register file read addresses
//   rf_d_out_a/b        register file combinational read data
//   rf_wr, rf_wr_addr, rf_d_in  register file write port
//   flag_z, flag_c      zero / carry flags (only with RF_SEQ_FLAGS_EN)
// Optional feature macro: RF_SEQ_FLAGS_EN.
module rf_seq
    import rf_seq_pkg::*;
#(
    parameter int unsigned W    = 16,
    parameter int unsigned NREG = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [W-1:0]            instr,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    output logic                    done,
    output logic [W-1:0]            result,
    output logic [$clog2(NREG)-1:0] rf_rd_addr_a,
    output logic [$clog2(NREG)-1:0] rf_rd_addr_b,
    input  logic [W-1:0]            rf_d_out_a,
    input  logic [W-1:0]            rf_d_out_b,
    output logic                    rf_wr,
    output logic [$clog2(NREG)-1:0] rf_wr_addr,
    output logic [W-1:0]            rf_d_in
`ifdef RF_SEQ_FLAGS_EN
    ,
    output logic                    flag_z,
    output logic                    flag_c
`endif
);

    localparam int unsigned AW = $clog2(NREG);
    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    logic [2:0]    state;
    logic [W-1:0]  instr_q;
    logic [W-1:0]  result_q;
    logic [AW-1:0] clr_cnt;

    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] ra_q;
    logic [AW-1:0] rb_q;
    logic [W-1:0]  alu_y;
    logic          alu_carry;
    logic          clr_last;

    assign op_q     = instr_q[OP_LSB +: 3];
    assign rd_q     = instr_q[RD_LSB +: AW];
    assign ra_q     = instr_q[RA_LSB +: AW];
    assign rb_q     = instr_q[RB_LSB +: AW];
    assign clr_last = (state == S_CLR) && (clr_cnt == LAST_REG);
    assign result   = result_q;

    rf_seq_alu u_alu (
        .op    (op_q),
        .a     (rf_d_out_a),
        .b     (rf_d_out_b),
        .imm   (instr_q[IMM_W-1:0]),
        .y     (alu_y),
        .carry (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            instr_q  <= '0;
            result_q <= '0;
            clr_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        if (instr[OP_LSB +: 3] == OP_CLRALL) begin
                            state    <= S_CLR;
                            clr_cnt  <= '0;
                            result_q <= '0;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: state <= S_EXEC;
                S_EXEC: begin
                    result_q <= alu_y;
                    state    <= S_WB;
                end
                S_WB:   state <= S_IDLE;
                S_CLR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_last) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Writes and done are masked by reset so an interrupted CLR stops before
    // touching the register addressed in the reset cycle.
    always_comb begin
        instr_ready  = (state == S_IDLE);
        done         = 1'b0;
        rf_rd_addr_a = '0;
        rf_rd_addr_b = '0;
        rf_wr        = 1'b0;
        rf_wr_addr   = '0;
        rf_d_in      = '0;
        case (state)
            S_READ, S_EXEC: begin
                rf_rd_addr_a = ra_q;
                rf_rd_addr_b = rb_q;
            end
            S_WB: begin
                rf_wr      = !reset;
                rf_wr_addr = rd_q;
                rf_d_in    = result_q;
                done       = !reset;
            end
            S_CLR: begin
                rf_wr      = !reset;
                rf_wr_addr = clr_cnt;
                done       = clr_last && !reset;
            end
            default: ;
        endcase
    end

`ifdef RF_SEQ_FLAGS_EN
    logic carry_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            if (state == S_EXEC) begin
                carry_q <= alu_carry;
            end
            if (state == S_WB) begin
                flag_z <= (result_q == '0);
                flag_c <= carry_q;
            end
            if (clr_last) begin
                flag_z <= 1'b1;
                flag_c <= 1'b0;
            end
        end
    end
`else
    logic carry_unused;
    assign carry_unused = alu_carry;
`endif

endmodule

// File: tb/tb_rf_seq.sv
// tb_rf_seq -- self-checking bench for rf_seq.
//   Contains a behavioural 8x16 register file wired to the sequencer, a
//   register-content model, and a scoreboard of expected writes.
//   Flag checks are included when RF_SEQ_FLAGS_EN is defined.
module tb_rf_seq;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
    logic [15:0] result;
    logic [2:0]  rf_rd_addr_a;
    logic [2:0]  rf_rd_addr_b;
    logic [15:0] rf_d_out_a;
    logic [15:0] rf_d_out_b;
    logic        rf_wr;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_d_in;
`ifdef RF_SEQ_FLAGS_EN
    logic        flag_z;
    logic        flag_c;
`endif

    rf_seq #(.W(16), .NREG(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .done         (done),
        .result       (result),
        .rf_rd_addr_a (rf_rd_addr_a),
        .rf_rd_addr_b (rf_rd_addr_b),
        .rf_d_out_a   (rf_d_out_a),
        .rf_d_out_b   (rf_d_out_b),
        .rf_wr        (rf_wr),
        .rf_wr_addr   (rf_wr_addr),
        .rf_d_in      (rf_d_in)
`ifdef RF_SEQ_FLAGS_EN
        ,
        .flag_z       (flag_z),
        .flag_c       (flag_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file: no content reset, combinational reads
    logic [15:0] rf [8];
    always @(posedge clk) begin
        if (rf_wr) rf[rf_wr_addr] <= rf_d_in;
    end
    assign rf_d_out_a = rf[rf_rd_addr_a];
    assign rf_d_out_b = rf[rf_rd_addr_b];

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t         sb[$];
    logic [15:0] mdl [8];
    int          vec  = 0;
    int          errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
        return {op, rd, ra, rb, 4'b0000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
        return {3'b110, rd, imm};
    endfunction

    task automatic chk_rf(input string tag);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", tag, i), rf[i], mdl[i]);
    endtask

    // Issue one instruction starting at a negedge; returns at the negedge of
    // the first cycle after done. With hold=1, instr_valid stays high with nxt.
    task automatic exec(input logic [15:0] ins, input logic hold, input logic [15:0] nxt);
        logic [2:0]  op, rd, ra, rb;
        logic [15:0] a, b, y;
        logic [16:0] s;
        logic        c;
        int          lat, nexp, nwr, done_cyc, w;
        wr_t         e;
        op = ins[15:13]; rd = ins[12:10]; ra = ins[9:7]; rb = ins[6:4];
        a = mdl[ra]; b = mdl[rb]; c = 1'b0; s = '0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[15:0]; c = s[16]; end
            3'd1: begin y = a - b; c = (a < b); end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = a;
            3'd6: y = {6'b0, ins[9:0]};
            default: y = 16'h0000;
        endcase
        if (op == 3'd7) begin
            for (int i = 0; i < 8; i++) begin
                e.addr = 3'(i); e.data = 16'h0000; e.cyc = i + 1;
                sb.push_back(e);
                mdl[i] = 16'h0000;
            end
            lat = 8; nexp = 8;
        end else begin
            e.addr = rd; e.data = y; e.cyc = 3;
            sb.push_back(e);
            mdl[rd] = y;
            lat = 3; nexp = 1;
        end

        instr = ins; instr_valid = 1'b1; w = 0;
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", (w < 20), 1);
        @(posedge clk);
        #1;
        if (hold) instr = nxt;
        else begin
            instr_valid = 1'b0;
            instr = 16'h0000;
        end

        nwr = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk("busy_ready", instr_ready, 0);
            if (rf_wr) begin
                nwr++;
                chk("write_expected", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", rf_wr_addr, e.addr);
                    chk("wr_data", rf_d_in, e.data);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                done_cyc = cyc;
                chk("result", result, y);
                break;
            end
        end
        chk("done_cycle", done_cyc, lat);
        chk("write_count", nwr, nexp);
        chk("sb_drained", sb.size(), 0);
        sb.delete();

        @(negedge clk);
        chk("ready_again", instr_ready, 1);
        chk("wr_idle", rf_wr, 0);
        chk("done_single", done, 0);
`ifdef RF_SEQ_FLAGS_EN
        chk("flag_z", flag_z, (op == 3'd7) ? 1'b1 : (y == 16'h0000));
        chk("flag_c", flag_c, (op == 3'd7) ? 1'b0 : c);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        reset = 1'b1; instr = 16'h0000; instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_wr", rf_wr, 0);
        chk("rst_addr_a", rf_rd_addr_a, 0);
        chk("rst_addr_b", rf_rd_addr_b, 0);
        chk("rst_wr_addr", rf_wr_addr, 0);
        chk("rst_d_in", rf_d_in, 0);
        chk("rst_result", result, 0);
`ifdef RF_SEQ_FLAGS_EN
        chk("rst_flag_z", flag_z, 0);
        chk("rst_flag_c", flag_c, 0);
`endif

        // LDI r1,#5 ; LDI r2,#3 ; ADD r3,r1,r2 ; SUB r4,r2,r1
        exec(16'hC405, 1'b0, 16'h0000);
        exec(ldi(3'd2, 10'd3), 1'b0, 16'h0000);
        exec(enc(3'd0, 3'd3, 3'd1, 3'd2), 1'b0, 16'h0000);
        chk("add_r3", rf[3], 16'h0008);
        exec(enc(3'd1, 3'd4, 3'd2, 3'd1), 1'b0, 16'h0000);
        chk("sub_r4", rf[4], 16'hFFFE);

        // Valid held high with a different word while busy
        exec(enc(3'd2, 3'd5, 3'd1, 3'd2), 1'b1, enc(3'd3, 3'd6, 3'd3, 3'd4));
        exec(enc(3'd3, 3'd6, 3'd3, 3'd4), 1'b0, 16'h0000);
        exec(enc(3'd4, 3'd7, 3'd1, 3'd4), 1'b0, 16'h0000);
        exec(enc(3'd5, 3'd0, 3'd3, 3'd0), 1'b0, 16'h0000);
        chk_rf("after_alu");

        // Build r1 = 0x8000 by doubling, then wrap with ADD r1,r1,r1
        exec(ldi(3'd1, 10'h200), 1'b0, 16'h0000);
        for (int i = 0; i < 6; i++) exec(enc(3'd0, 3'd1, 3'd1, 3'd1), 1'b0, 16'h0000);
        chk("r1_8000", rf[1], 16'h8000);
        exec(enc(3'd0, 3'd1, 3'd1, 3'd1), 1'b0, 16'h0000);
        chk("add_wrap", rf[1], 16'h0000);

        // Full load then CLRALL
        for (int i = 0; i < 8; i++) exec(ldi(3'(i), 10'(i + 1)), 1'b0, 16'h0000);
        chk_rf("loaded");
        exec(16'hE000, 1'b0, 16'h0000);
        chk_rf("cleared");

        // Reset while the clear counter is at 3
        for (int i = 0; i < 8; i++) exec(ldi(3'(i), 10'(16'h100 + i)), 1'b0, 16'h0000);
        instr = 16'hE000; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0; instr = 16'h0000;
        for (int cyc = 1; cyc <= 4; cyc++) @(negedge clk);
        chk("clr_at3_wr", rf_wr, 1);
        chk("clr_at3_addr", rf_wr_addr, 3);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_wr", rf_wr, 0);
        chk("abort_ready", instr_ready, 1);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        for (int i = 0; i < 3; i++) mdl[i] = 16'h0000;
        chk_rf("abort");

        // Random ALU/LDI traffic
        for (int i = 0; i < 12; i++) begin
            logic [2:0] rop;
            rop = 3'($urandom_range(0, 6));
            if (rop == 3'd6) exec(ldi(3'($urandom_range(0, 7)), 10'($urandom)), 1'b0, 16'h0000);
            else exec(enc(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7))), 1'b0, 16'h0000);
        end
        chk_rf("random");

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
